kb_field_editor: RTL and testbench

- Parametrised successor of the keyboard control block; turns PS/2 scan-code pairs into register writes for the clock/date/timer register file.
- Adds configurable field groups, field count and digit width, Backspace editing, and a valid/ack commit handshake that replaces the free-running commit flag.
- Sits between the PS/2 receiver, which provides a 16-bit {prev_byte, last_byte} buffer, and the register-file write port.

---
 rtl/kb_pkg.sv | 57 +++++
 rtl/kb_field_editor_scan_decode.sv | 47 ++++
 rtl/kb_field_editor.sv | 248 ++++++++++++++++++++++++
 tb/tb_kb_field_editor.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kb_pkg.sv
// -----------------------------------------------------------------------------
// kb_pkg
// Shared definitions for the keyboard field editor: PS/2 set-2 scan codes,
// the key classes produced by the scan decoder, the editor states and the
// "no group selected" encoding.
// -----------------------------------------------------------------------------
package kb_pkg;

    // Function / control keys
    localparam logic [7:0] SC_F1    = 8'h05;
    localparam logic [7:0] SC_F2    = 8'h06;
    localparam logic [7:0] SC_F3    = 8'h04;
    localparam logic [7:0] SC_F11   = 8'h78;
    localparam logic [7:0] SC_F12   = 8'h07;
    localparam logic [7:0] SC_ESC   = 8'h76;
    localparam logic [7:0] SC_TAB   = 8'h0D;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_BKSP  = 8'h66;

    // Prefix bytes: break (key released) and extended key
    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;

    // Top-row digits 0..9
    localparam logic [7:0] SC_D0 = 8'h45;
    localparam logic [7:0] SC_D1 = 8'h16;
    localparam logic [7:0] SC_D2 = 8'h1E;
    localparam logic [7:0] SC_D3 = 8'h26;
    localparam logic [7:0] SC_D4 = 8'h25;
    localparam logic [7:0] SC_D5 = 8'h2E;
    localparam logic [7:0] SC_D6 = 8'h36;
    localparam logic [7:0] SC_D7 = 8'h3D;
    localparam logic [7:0] SC_D8 = 8'h3E;
    localparam logic [7:0] SC_D9 = 8'h46;

    // Group output value when no field group is selected
    localparam logic [1:0] GRP_NONE = 2'd3;

    typedef enum logic [3:0] {
        K_NONE  = 4'd0,
        K_DIGIT = 4'd1,
        K_GRP   = 4'd2,
        K_TON   = 4'd3,
        K_TOFF  = 4'd4,
        K_TAB   = 4'd5,
        K_ENTER = 4'd6,
        K_BKSP  = 4'd7,
        K_ESC   = 4'd8
    } key_class_e;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        EDIT     = 2'd1,
        WAIT_ACK = 2'd2
    } state_e;

endpackage

// File: rtl/kb_field_editor_scan_decode.sv
// -----------------------------------------------------------------------------
// kb_scan_decode
// Purely combinational classifier for a single PS/2 scan byte.
//   i_code  : scan byte (the latest byte of the receiver buffer)
//   o_class : key class (K_NONE for any code the editor does not use)
//   o_digit : BCD value when o_class == K_DIGIT, else 0
//   o_group : field group 0..2 when o_class == K_GRP, else GRP_NONE
// -----------------------------------------------------------------------------
module kb_scan_decode
    import kb_pkg::*;
(
    input  logic [7:0] i_code,
    output key_class_e o_class,
    output logic [3:0] o_digit,
    output logic [1:0] o_group
);

    // Scan byte to key class / digit / group lookup
    always_comb begin
        o_class = K_NONE;
        o_digit = 4'd0;
        o_group = GRP_NONE;
        case (i_code)
            SC_D0:    begin o_class = K_DIGIT; o_digit = 4'd0; end
            SC_D1:    begin o_class = K_DIGIT; o_digit = 4'd1; end
            SC_D2:    begin o_class = K_DIGIT; o_digit = 4'd2; end
            SC_D3:    begin o_class = K_DIGIT; o_digit = 4'd3; end
            SC_D4:    begin o_class = K_DIGIT; o_digit = 4'd4; end
            SC_D5:    begin o_class = K_DIGIT; o_digit = 4'd5; end
            SC_D6:    begin o_class = K_DIGIT; o_digit = 4'd6; end
            SC_D7:    begin o_class = K_DIGIT; o_digit = 4'd7; end
            SC_D8:    begin o_class = K_DIGIT; o_digit = 4'd8; end
            SC_D9:    begin o_class = K_DIGIT; o_digit = 4'd9; end
            SC_F1:    begin o_class = K_GRP;   o_group = 2'd0; end
            SC_F2:    begin o_class = K_GRP;   o_group = 2'd1; end
            SC_F3:    begin o_class = K_GRP;   o_group = 2'd2; end
            SC_F11:   o_class = K_TON;
            SC_F12:   o_class = K_TOFF;
            SC_TAB:   o_class = K_TAB;
            SC_ENTER: o_class = K_ENTER;
            SC_BKSP:  o_class = K_BKSP;
            SC_ESC:   o_class = K_ESC;
            default:  o_class = K_NONE;
        endcase
    end

endmodule

// File: rtl/kb_field_editor.sv
// -----------------------------------------------------------------------------
// kb_field_editor
// Turns {previous, latest} PS/2 scan bytes into register-file writes for the
// date / clock / timer field groups. F1..F3 pick a group, digits build a
// packed BCD value, Tab walks the fields of the group (descending addresses),
// Enter or F11/F12 raise a commit that is held until acknowledged, and an Esc
// release aborts everything.
// Ports:
//   CLK, RESET    : clock, synchronous active-high reset
//   KBBuffer      : {previous scan byte, latest scan byte}
//   Commit_Ack    : consumer accepts the pending commit
//   Commit_Valid  : commit pending, held until acked
//   Address, Data : register-file write address / packed BCD data
//   Group         : 0=date 1=clock 2=timer 3=none
//   Field_Idx     : current field within the group
//   Digit_Cnt     : digits entered, saturating at DIGITS
// -----------------------------------------------------------------------------
module kb_field_editor
    import kb_pkg::*;
#(
    parameter  int DIGITS          = 2,
    parameter  int ADDR_W          = 8,
    parameter  int FIELDS          = 3,
    parameter  int BASE_DATE       = 22,
    parameter  int BASE_CLOCK      = 19,
    parameter  int BASE_TIMER      = 25,
    parameter  int TIMER_CTRL_ADDR = 28,
    parameter  int TIMER_ON_VAL    = 8,
    localparam int DATA_W          = 4 * DIGITS,
    localparam int FI_W            = (FIELDS > 1) ? $clog2(FIELDS) : 1,
    localparam int CNT_W           = $clog2(DIGITS + 1)
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [15:0]       KBBuffer,
    input  logic              Commit_Ack,
    output logic              Commit_Valid,
    output logic [ADDR_W-1:0] Address,
    output logic [DATA_W-1:0] Data,
    output logic [1:0]        Group,
    output logic [FI_W-1:0]   Field_Idx,
    output logic [CNT_W-1:0]  Digit_Cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(DIGITS);
    localparam logic [FI_W-1:0]  FIELD_LAST = FI_W'(FIELDS - 1);

    // Base address of a field group (field 0 sits at the base)
    function automatic logic [ADDR_W-1:0] base_of(input logic [1:0] g);
        case (g)
            2'd0:    base_of = ADDR_W'(BASE_DATE);
            2'd1:    base_of = ADDR_W'(BASE_CLOCK);
            2'd2:    base_of = ADDR_W'(BASE_TIMER);
            default: base_of = {ADDR_W{1'b0}};
        endcase
    endfunction

    // Registered state and outputs
    state_e             r_state;
    logic [15:0]        r_kb_prev;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_data;
    logic               r_cv;
    logic [1:0]         r_group;
    logic [FI_W-1:0]    r_field;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_from_edit;   // pending commit returns to EDIT (else IDLE)

    // Next-state values
    state_e             w_state_nx;
    logic [ADDR_W-1:0]  w_addr_nx;
    logic [DATA_W-1:0]  w_data_nx;
    logic               w_cv_nx;
    logic [1:0]         w_group_nx;
    logic [FI_W-1:0]    w_field_nx;
    logic [CNT_W-1:0]   w_cnt_nx;
    logic               w_from_edit_nx;

    // Decoder outputs and event qualifiers
    key_class_e         w_class;
    logic [3:0]         w_digit;
    logic [1:0]         w_grp_idx;
    logic               w_event;
    logic               w_make_ev;
    logic               w_esc_ev;

    kb_scan_decode u_decode (
        .i_code  (KBBuffer[7:0]),
        .o_class (w_class),
        .o_digit (w_digit),
        .o_group (w_grp_idx)
    );

    // A new buffer value is one key event; E0-prefixed makes are ignored and
    // only the Esc release acts among break codes.
    assign w_event   = (KBBuffer != r_kb_prev);
    assign w_make_ev = w_event && (KBBuffer[15:8] != SC_BREAK) && (KBBuffer[15:8] != SC_EXT);
    assign w_esc_ev  = w_event && (KBBuffer[15:8] == SC_BREAK) && (w_class == K_ESC);

    // Next-state and next-output computation
    always_comb begin
        w_state_nx     = r_state;
        w_addr_nx      = r_addr;
        w_data_nx      = r_data;
        w_cv_nx        = r_cv;
        w_group_nx     = r_group;
        w_field_nx     = r_field;
        w_cnt_nx       = r_cnt;
        w_from_edit_nx = r_from_edit;

        if (w_esc_ev) begin
            // Abort beats a simultaneous Commit_Ack: the commit is discarded.
            w_state_nx     = IDLE;
            w_addr_nx      = {ADDR_W{1'b0}};
            w_data_nx      = {DATA_W{1'b0}};
            w_cv_nx        = 1'b0;
            w_group_nx     = GRP_NONE;
            w_field_nx     = {FI_W{1'b0}};
            w_cnt_nx       = {CNT_W{1'b0}};
            w_from_edit_nx = 1'b0;
        end else begin
            case (r_state)
                WAIT_ACK: begin
                    // Address/Data frozen, keys dropped; only the ack matters.
                    if (Commit_Ack && r_cv) begin
                        w_cv_nx   = 1'b0;
                        w_data_nx = {DATA_W{1'b0}};
                        w_cnt_nx  = {CNT_W{1'b0}};
                        if (r_from_edit) begin
                            w_state_nx = EDIT;
                        end else begin
                            w_state_nx = IDLE;
                            w_group_nx = GRP_NONE;
                            w_field_nx = {FI_W{1'b0}};
                        end
                    end else begin
                        w_state_nx = WAIT_ACK;
                    end
                end

                IDLE, EDIT: begin
                    if (w_make_ev) begin
                        case (w_class)
                            K_GRP: begin
                                w_state_nx = EDIT;
                                w_group_nx = w_grp_idx;
                                w_addr_nx  = base_of(w_grp_idx);
                                w_field_nx = {FI_W{1'b0}};
                                w_data_nx  = {DATA_W{1'b0}};
                                w_cnt_nx   = {CNT_W{1'b0}};
                            end
                            K_TON, K_TOFF: begin
                                w_state_nx     = WAIT_ACK;
                                w_addr_nx      = ADDR_W'(TIMER_CTRL_ADDR);
                                w_data_nx      = (w_class == K_TON) ? DATA_W'(TIMER_ON_VAL)
                                                                    : {DATA_W{1'b0}};
                                w_cv_nx        = 1'b1;
                                w_from_edit_nx = 1'b0;
                            end
                            K_DIGIT: begin
                                if (r_state == EDIT) begin
                                    // Newest digit enters at [3:0]; oldest falls off the top.
                                    w_data_nx = {r_data[DATA_W-5:0], w_digit};
                                    w_cnt_nx  = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);
                                end else begin
                                    w_data_nx = r_data;
                                end
                            end
                            K_BKSP: begin
                                if (r_state == EDIT) begin
                                    w_data_nx = r_data >> 4;
                                    w_cnt_nx  = (r_cnt == {CNT_W{1'b0}}) ? r_cnt : r_cnt - CNT_W'(1);
                                end else begin
                                    w_data_nx = r_data;
                                end
                            end
                            K_TAB: begin
                                if (r_state == EDIT) begin
                                    // Fields occupy descending addresses from the base.
                                    if (r_field == FIELD_LAST) begin
                                        w_field_nx = {FI_W{1'b0}};
                                        w_addr_nx  = base_of(r_group);
                                    end else begin
                                        w_field_nx = r_field + FI_W'(1);
                                        w_addr_nx  = r_addr - ADDR_W'(1);
                                    end
                                    w_data_nx = {DATA_W{1'b0}};
                                    w_cnt_nx  = {CNT_W{1'b0}};
                                end else begin
                                    w_field_nx = r_field;
                                end
                            end
                            K_ENTER: begin
                                if ((r_state == EDIT) && (r_cnt != {CNT_W{1'b0}})) begin
                                    w_state_nx     = WAIT_ACK;
                                    w_cv_nx        = 1'b1;
                                    w_from_edit_nx = 1'b1;
                                end else begin
                                    w_cv_nx = r_cv;
                                end
                            end
                            default: w_state_nx = r_state;
                        endcase
                    end else begin
                        w_state_nx = r_state;
                    end
                end

                default: w_state_nx = IDLE;
            endcase
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state     <= IDLE;
            r_kb_prev   <= 16'h0000;
            r_addr      <= {ADDR_W{1'b0}};
            r_data      <= {DATA_W{1'b0}};
            r_cv        <= 1'b0;
            r_group     <= GRP_NONE;
            r_field     <= {FI_W{1'b0}};
            r_cnt       <= {CNT_W{1'b0}};
            r_from_edit <= 1'b0;
        end else begin
            if (w_event) begin
                r_kb_prev <= KBBuffer;
            end
            r_state     <= w_state_nx;
            r_addr      <= w_addr_nx;
            r_data      <= w_data_nx;
            r_cv        <= w_cv_nx;
            r_group     <= w_group_nx;
            r_field     <= w_field_nx;
            r_cnt       <= w_cnt_nx;
            r_from_edit <= w_from_edit_nx;
        end
    end

    assign Commit_Valid = r_cv;
    assign Address      = r_addr;
    assign Data         = r_data;
    assign Group        = r_group;
    assign Field_Idx    = r_field;
    assign Digit_Cnt    = r_cnt;

endmodule

// File: tb/tb_kb_field_editor.sv
// -----------------------------------------------------------------------------
// tb_kb_field_editor
// Directed stimulus for kb_field_editor (default parameters). A key-level
// behavioural model predicts every output each cycle; literal checks at
// key points pin the expected values independently of the model.
// -----------------------------------------------------------------------------
module tb_kb_field_editor;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [15:0] KBBuffer;
    logic        Commit_Ack;
    logic        Commit_Valid;
    logic [7:0]  Address;
    logic [7:0]  Data;
    logic [1:0]  Group;
    logic [1:0]  Field_Idx;
    logic [1:0]  Digit_Cnt;

    kb_field_editor dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .KBBuffer     (KBBuffer),
        .Commit_Ack   (Commit_Ack),
        .Commit_Valid (Commit_Valid),
        .Address      (Address),
        .Data         (Data),
        .Group        (Group),
        .Field_Idx    (Field_Idx),
        .Digit_Cnt    (Digit_Cnt)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model (key level) ----------------
    // m_state: 0 = no group, 1 = editing, 2 = commit pending
    int          m_state, m_grp, m_fld, m_addr, m_data, m_cnt, m_cv, m_from_edit;
    logic [15:0] m_prev;
    logic [7:0]  m_hi, m_lo;
    bit          m_ev;
    int          m_d;

    function automatic int digit_of(input logic [7:0] c);
        case (c)
            8'h45: return 0;
            8'h16: return 1;
            8'h1E: return 2;
            8'h26: return 3;
            8'h25: return 4;
            8'h2E: return 5;
            8'h36: return 6;
            8'h3D: return 7;
            8'h3E: return 8;
            8'h46: return 9;
            default: return -1;
        endcase
    endfunction

    function automatic int base_addr(input int g);
        if (g == 0) return 22;
        if (g == 1) return 19;
        return 25;
    endfunction

    task automatic model_clear();
        m_state = 0; m_grp = 3; m_fld = 0; m_addr = 0;
        m_data = 0; m_cnt = 0; m_cv = 0; m_from_edit = 0;
    endtask

    always @(posedge CLK) begin
        if (RESET) begin
            model_clear();
            m_prev = 16'h0000;
        end else begin
            m_ev = (KBBuffer != m_prev);
            m_hi = KBBuffer[15:8];
            m_lo = KBBuffer[7:0];
            if (m_ev) m_prev = KBBuffer;
            if (m_ev && m_hi == 8'hF0 && m_lo == 8'h76) begin
                model_clear();
            end else if (m_state == 2) begin
                if (Commit_Ack) begin
                    m_cv = 0; m_data = 0; m_cnt = 0;
                    if (m_from_edit != 0) begin
                        m_state = 1;
                    end else begin
                        m_state = 0; m_grp = 3; m_fld = 0;
                    end
                end
            end else if (m_ev && m_hi != 8'hF0 && m_hi != 8'hE0) begin
                m_d = digit_of(m_lo);
                if (m_lo == 8'h05 || m_lo == 8'h06 || m_lo == 8'h04) begin
                    m_grp   = (m_lo == 8'h05) ? 0 : (m_lo == 8'h06) ? 1 : 2;
                    m_addr  = base_addr(m_grp);
                    m_fld   = 0; m_data = 0; m_cnt = 0; m_state = 1;
                end else if (m_lo == 8'h78 || m_lo == 8'h07) begin
                    m_addr = 28;
                    m_data = (m_lo == 8'h78) ? 8 : 0;
                    m_cv = 1; m_state = 2; m_from_edit = 0;
                end else if (m_state == 1) begin
                    if (m_d >= 0) begin
                        m_data = (m_data * 16 + m_d) % 256;
                        if (m_cnt < 2) m_cnt++;
                    end else if (m_lo == 8'h66) begin
                        m_data = m_data / 16;
                        if (m_cnt > 0) m_cnt--;
                    end else if (m_lo == 8'h0D) begin
                        if (m_fld == 2) begin
                            m_fld = 0; m_addr = base_addr(m_grp);
                        end else begin
                            m_fld++; m_addr = (m_addr + 255) % 256;
                        end
                        m_data = 0; m_cnt = 0;
                    end else if (m_lo == 8'h5A && m_cnt > 0) begin
                        m_cv = 1; m_state = 2; m_from_edit = 1;
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare against the model ----------------
    always @(negedge CLK) begin
        if (chk_en) begin
            check("m_valid", Commit_Valid, m_cv);
            check("m_addr",  Address,      m_addr);
            check("m_data",  Data,         m_data);
            check("m_group", Group,        m_grp);
            check("m_field", Field_Idx,    m_fld);
            check("m_cnt",   Digit_Cnt,    m_cnt);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic send(input logic [15:0] v);
        KBBuffer = v;
        @(negedge CLK);
    endtask

    task automatic ack_pulse();
        Commit_Ack = 1'b1;
        @(negedge CLK);
        Commit_Ack = 1'b0;
    endtask

    initial begin
        RESET = 1'b1; KBBuffer = 16'h0000; Commit_Ack = 1'b0;
        repeat (3) @(negedge CLK);
        chk_en = 1'b1;
        RESET = 1'b0;
        @(negedge CLK);
        check("rst_addr", Address, 0);
        check("rst_group", Group, 3);
        check("rst_valid", Commit_Valid, 0);
        check("rst_data", Data, 0);

        // F1, 1, 2
        send(16'h0005); send(16'h0016); send(16'h001E);
        check("f1_group", Group, 0);
        check("f1_addr", Address, 22);
        check("f1_data", Data, 8'h12);
        check("f1_cnt", Digit_Cnt, 2);
        check("f1_valid", Commit_Valid, 0);

        // Enter, held 5 cycles without ack, then ack
        send(16'h005A);
        check("ent_valid", Commit_Valid, 1);
        check("ent_addr", Address, 22);
        check("ent_data", Data, 8'h12);
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            check("hold_valid", Commit_Valid, 1);
        end
        ack_pulse();
        check("ack_valid", Commit_Valid, 0);
        check("ack_addr", Address, 22);
        check("ack_data", Data, 0);
        check("ack_group", Group, 0);

        // Still editing: digit 3 accepted; stray ack ignored
        send(16'h0026);
        check("edit_data", Data, 8'h03);
        ack_pulse();
        check("stray_ack", Digit_Cnt, 1);

        // F2 then Tab x3 (break codes in between are ignored)
        send(16'h0006);
        check("f2_addr", Address, 19);
        send(16'h000D);
        check("tab1_addr", Address, 18); check("tab1_fld", Field_Idx, 1);
        send(16'hF00D);
        send(16'h0D0D);
        check("tab2_addr", Address, 17); check("tab2_fld", Field_Idx, 2);
        send(16'hF00D);
        send(16'h0D0D);
        check("tab3_addr", Address, 19); check("tab3_fld", Field_Idx, 0);

        // F3, 4 5 6, Backspace
        send(16'h0004); send(16'h0025); send(16'h002E); send(16'h0036);
        check("f3_data", Data, 8'h56);
        send(16'h0066);
        check("bk_data", Data, 8'h05);
        check("bk_cnt", Digit_Cnt, 1);
        check("f3_addr", Address, 25);

        // Extended Enter ignored; real Enter commits; Tab dropped while pending
        send(16'hE05A);
        check("ext_valid", Commit_Valid, 0);
        send(16'h005A);
        check("ent2_valid", Commit_Valid, 1);
        send(16'h000D);
        check("wait_addr", Address, 25);
        check("wait_data", Data, 8'h05);
        ack_pulse();
        check("ack2_group", Group, 2);

        // Esc back to IDLE; digits ignored there
        send(16'hF076);
        check("esc_group", Group, 3);
        send(16'h0016);
        check("idle_cnt", Digit_Cnt, 0);

        // F11, then Esc together with ack: abort wins
        send(16'h0078);
        check("f11_addr", Address, 28);
        check("f11_data", Data, 8'h08);
        check("f11_valid", Commit_Valid, 1);
        KBBuffer = 16'hF076;
        ack_pulse();
        check("abort_valid", Commit_Valid, 0);
        check("abort_addr", Address, 0);
        check("abort_data", Data, 0);
        check("abort_group", Group, 3);

        // F12 from IDLE, ack returns to IDLE
        send(16'h0007);
        check("f12_data", Data, 0);
        check("f12_valid", Commit_Valid, 1);
        ack_pulse();
        check("f12_ack", Commit_Valid, 0);
        check("f12_group", Group, 3);

        // F1, Enter with no digits, repeated buffer, break of 1: no change
        send(16'h0005);
        send(16'h005A);
        check("empty_ent", Commit_Valid, 0);
        repeat (3) @(negedge CLK);
        send(16'hF016);
        check("brk_cnt", Digit_Cnt, 0);
        check("brk_data", Data, 0);

        // Saturation at two digits, then Backspace down past zero
        send(16'h0016); send(16'h001E); send(16'h0045);
        check("sat_data", Data, 8'h20);
        check("sat_cnt", Digit_Cnt, 2);
        send(16'h0066);
        check("bk1_data", Data, 8'h02);
        send(16'hF066); send(16'h6666);
        check("bk2_cnt", Digit_Cnt, 0);
        send(16'hF066); send(16'h0066);
        check("bk3_cnt", Digit_Cnt, 0);
        check("bk3_data", Data, 0);

        // Reset in the middle of a pending commit
        send(16'h0016); send(16'h005A);
        check("pre_rst_valid", Commit_Valid, 1);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        check("mid_rst_valid", Commit_Valid, 0);
        check("mid_rst_group", Group, 3);
        repeat (2) @(negedge CLK);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
